// File: rtl/vram_arbiter_pkg.sv
// Shared types and widths for the video/main SRAM arbiter.
package vram_arbiter_pkg;

  localparam int unsigned AW_C = 19;
  localparam int unsigned DW_C = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2,
    WR3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCR,
    OWN_CPU,
    OWN_AUX
  } arb_owner_t;

endpackage

// File: rtl/vram_aux_fifo.sv
// Small write FIFO buffering auxiliary SRAM writes (palette, DMA).
module vram_aux_fifo
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = AW_C,
  parameter int unsigned DW    = DW_C
) (
  input  logic          clk28,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign push_ok     = push_i & ~full_o;
  assign pop_ok      = pop_i & ~empty_o;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + (PW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - (PW+1)'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk28) begin
    if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Clocked scheduler owning the shared video/main SRAM bus.
// Priority: screen > CPU > aux, with aux promoted over CPU after starving.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_C,
  parameter int unsigned DW         = DW_C,
  parameter int unsigned AUX_DEPTH  = 2,
  parameter int unsigned AUX_STARVE = 8
) (
  input  logic          clk28,
  input  logic          rst_n,
  input  logic          scr_req,
  input  logic [AW-1:0] scr_addr,
  output logic          scr_ack,
  output logic [DW-1:0] scr_data,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_data,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dout,
  output logic          sram_oe,
  input  logic [DW-1:0] sram_din,
  output logic          n_vrd,
  output logic          n_vwr
);

  localparam int unsigned SW = $clog2(AUX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = AUX_STARVE[SW-1:0];

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          scr_ack_q, scr_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] scr_data_q, scr_data_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] fifo_addr;
  logic [DW-1:0] fifo_data;

  logic          end_pt;
  logic          arb_pt;
  logic          scr_ok;
  logic          cpu_ok;
  logic          aux_ok;
  logic          aux_promoted;

  vram_aux_fifo #(
    .DEPTH(AUX_DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_aux_fifo (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .push_i     (aux_valid),
    .push_addr_i(aux_addr),
    .push_data_i(aux_data),
    .pop_i      (fifo_pop),
    .head_addr_o(fifo_addr),
    .head_data_o(fifo_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Arbitration points are IDLE and the final cycle of each access.
  // The finishing owner and any requester in its ack cycle are masked so
  // a held level request is never granted twice.
  assign end_pt       = (state_q == RD2) || (state_q == WR3);
  assign arb_pt       = end_pt || (state_q == IDLE);
  assign scr_ok       = scr_req & ~scr_ack_q & ~(end_pt && owner_q == OWN_SCR);
  assign cpu_ok       = cpu_req & ~cpu_ack_q & ~(end_pt && owner_q == OWN_CPU);
  assign aux_ok       = ~fifo_empty & ~(end_pt && owner_q == OWN_AUX);
  assign aux_promoted = aux_ok && (starve_q == STARVE_MAX);

  assign sram_a    = addr_q;
  assign sram_dout = wdata_q;
  assign scr_ack   = scr_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign scr_data  = scr_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_wait  = cpu_req & ~cpu_ack_q;
  assign aux_ready = ~fifo_full;

  // State, owner and datapath registers.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      scr_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      scr_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      scr_ack_q   <= scr_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      scr_data_q  <= scr_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Access sequencing, completion handling, grant selection and strobes.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    scr_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    scr_data_d  = scr_data_q;
    cpu_rdata_d = cpu_rdata_q;
    fifo_pop    = 1'b0;
    n_vrd       = 1'b1;
    n_vwr       = 1'b1;
    sram_oe     = 1'b0;

    case (state_q)
      IDLE: ;
      RD1: begin
        n_vrd   = 1'b0;
        state_d = RD2;
      end
      RD2: begin
        n_vrd = 1'b0;
        if (owner_q == OWN_SCR) begin
          scr_data_d = sram_din;
          scr_ack_d  = 1'b1;
        end else begin
          cpu_rdata_d = sram_din;
          cpu_ack_d   = 1'b1;
        end
      end
      WR1: begin
        sram_oe = 1'b1;
        state_d = WR2;
      end
      WR2: begin
        sram_oe = 1'b1;
        n_vwr   = 1'b0;
        state_d = WR3;
      end
      WR3: begin
        sram_oe = 1'b1;
        if (owner_q == OWN_CPU) cpu_ack_d = 1'b1;
        else                    fifo_pop  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (arb_pt) begin
      state_d = IDLE;
      if (scr_ok) begin
        state_d = RD1;
        owner_d = OWN_SCR;
        addr_d  = scr_addr;
      end else if (cpu_ok && !aux_promoted) begin
        state_d = cpu_wr ? WR1 : RD1;
        owner_d = OWN_CPU;
        addr_d  = cpu_addr;
        if (cpu_wr) wdata_d = cpu_wdata;
        if (aux_ok && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
      end else if (aux_ok) begin
        state_d  = WR1;
        owner_d  = OWN_AUX;
        addr_d   = fifo_addr;
        wdata_d  = fifo_data;
        starve_d = '0;
      end
    end

    if (fifo_empty) starve_d = '0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int AW     = 19;
  localparam int DW     = 8;
  localparam int DEPTH  = 2;
  localparam int STARVE = 8;

  logic          clk28 = 1'b0;
  logic          rst_n;
  logic          scr_req, cpu_req, cpu_wr, aux_valid;
  logic [AW-1:0] scr_addr, cpu_addr, aux_addr;
  logic [DW-1:0] cpu_wdata, aux_data, sram_din;
  logic          scr_ack, cpu_ack, cpu_wait, aux_ready, sram_oe, n_vrd, n_vwr;
  logic [DW-1:0] scr_data, cpu_rdata, sram_dout;
  logic [AW-1:0] sram_a;

  int checks = 0;
  int errors = 0;

  always #5 clk28 = ~clk28;

  vram_arbiter #(.AW(AW), .DW(DW), .AUX_DEPTH(DEPTH), .AUX_STARVE(STARVE)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_ack(scr_ack), .scr_data(scr_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_oe(sram_oe), .sram_din(sram_din),
    .n_vrd(n_vrd), .n_vwr(n_vwr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one access in flight described by its owner,
  // direction, length and elapsed phase; aux writes held in a queue.
  bit                 started = 1'b0;
  bit                 m_busy, m_write, m_scr_ack, m_cpu_ack;
  int                 m_owner, m_phase, m_len, m_starve;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata, m_scr_data, m_cpu_rdata;
  logic [AW+DW-1:0]   mq[$];

  // Advance the reference model by one clock using the inputs present at the edge.
  always @(posedge clk28) begin
    bit last, arb, scr_ok, cpu_ok, aux_ok, nxt_sack, nxt_cack, pop, accept;
    int g;
    logic [AW+DW-1:0] head;
    if (!rst_n) begin
      started = 1'b1;
      m_busy = 0; m_write = 0; m_owner = 0; m_phase = 0; m_len = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_scr_data = '0; m_cpu_rdata = '0;
      m_scr_ack = 0; m_cpu_ack = 0;
      mq.delete();
    end else if (started) begin
      last = m_busy && (m_phase == m_len - 1);
      arb  = !m_busy || last;
      nxt_sack = 0; nxt_cack = 0; pop = 0;
      if (last) begin
        if (!m_write) begin
          if (m_owner == 1) begin m_scr_data = sram_din; nxt_sack = 1; end
          else begin m_cpu_rdata = sram_din; nxt_cack = 1; end
        end else if (m_owner == 2) nxt_cack = 1;
        else pop = 1;
      end
      scr_ok = scr_req && !m_scr_ack && !(last && m_owner == 1);
      cpu_ok = cpu_req && !m_cpu_ack && !(last && m_owner == 2);
      aux_ok = (mq.size() > 0) && !(last && m_owner == 3);
      g = 0;
      if (arb) begin
        if (scr_ok)                            g = 1;
        else if (aux_ok && m_starve >= STARVE) g = 3;
        else if (cpu_ok)                       g = 2;
        else if (aux_ok)                       g = 3;
      end
      if (mq.size() == 0)                              m_starve = 0;
      else if (g == 3)                                 m_starve = 0;
      else if (g == 2 && aux_ok && m_starve < STARVE)  m_starve++;
      accept = aux_valid && (mq.size() < DEPTH);
      if (arb) begin
        if (g == 1) begin
          m_addr = scr_addr; m_write = 0; m_len = 2;
        end else if (g == 2) begin
          m_addr = cpu_addr; m_write = cpu_wr; m_len = cpu_wr ? 3 : 2;
          if (cpu_wr) m_wdata = cpu_wdata;
        end else if (g == 3) begin
          head = mq[0];
          m_addr = head[AW+DW-1:DW]; m_wdata = head[DW-1:0]; m_write = 1; m_len = 3;
        end
        m_busy = (g != 0); m_owner = g; m_phase = 0;
      end else begin
        m_phase++;
      end
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back({aux_addr, aux_data});
      m_scr_ack = nxt_sack;
      m_cpu_ack = nxt_cack;
    end
  end

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk28) begin
    if (started) begin
      chk("n_vrd", 32'(n_vrd), 32'(!(m_busy && !m_write)));
      chk("n_vwr", 32'(n_vwr), 32'(!(m_busy && m_write && m_phase == 1)));
      chk("sram_oe", 32'(sram_oe), 32'(m_busy && m_write));
      chk("sram_a", 32'(sram_a), 32'(m_addr));
      if (m_busy && m_write) chk("sram_dout", 32'(sram_dout), 32'(m_wdata));
      chk("scr_ack", 32'(scr_ack), 32'(m_scr_ack));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
      chk("scr_data", 32'(scr_data), 32'(m_scr_data));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
      chk("aux_ready", 32'(aux_ready), 32'(mq.size() < DEPTH));
      chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !m_cpu_ack));
      chk("oe_and_rd", 32'(sram_oe && !n_vrd), 32'(0));
    end
  end

  task automatic step();
    @(posedge clk28);
    #2;
  endtask

  // Release requests as they are acknowledged and record write strobes.
  task automatic drain(input int cycles, output int nw, output logic [AW-1:0] wa0,
                       output logic [AW-1:0] wa1);
    nw = 0; wa0 = '0; wa1 = '0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (scr_ack) scr_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
      if (!n_vwr) begin
        if (nw == 0) wa0 = sram_a;
        if (nw == 1) wa1 = sram_a;
        nw++;
      end
    end
  endtask

  // Count CPU acks until the next aux write strobe; bounded wait.
  task automatic wait_aux_strobe(output int ncpu, output bit found);
    ncpu = 0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (cpu_ack) ncpu++;
      if (!n_vwr) found = 1;
    end
  endtask

  initial begin
    int nw, ncpu, nstrobe, nack;
    bit found;
    logic [AW-1:0] wa0, wa1;

    rst_n = 0; scr_req = 0; cpu_req = 0; cpu_wr = 0; aux_valid = 0;
    scr_addr = '0; cpu_addr = '0; aux_addr = '0; cpu_wdata = '0; aux_data = '0; sram_din = '0;
    repeat (3) step();
    chk("rst_n_vrd", 32'(n_vrd), 32'(1));
    chk("rst_n_vwr", 32'(n_vwr), 32'(1));
    chk("rst_oe", 32'(sram_oe), 32'(0));
    chk("rst_sram_a", 32'(sram_a), 32'(0));
    chk("rst_aux_ready", 32'(aux_ready), 32'(1));
    chk("rst_scr_data", 32'(scr_data), 32'(0));
    rst_n = 1;
    step();

    // Idle screen read.
    scr_req = 1; scr_addr = 19'h7C000; sram_din = 8'hA5;
    step();
    chk("scr_rd1_vrd", 32'(n_vrd), 32'(0));
    chk("scr_rd1_addr", 32'(sram_a), 32'h7C000);
    step();
    chk("scr_rd2_vrd", 32'(n_vrd), 32'(0));
    step();
    chk("scr_ack_n3", 32'(scr_ack), 32'(1));
    chk("scr_data_a5", 32'(scr_data), 32'hA5);
    chk("model_scr_data", 32'(m_scr_data), 32'hA5);
    scr_req = 0;
    step();
    chk("scr_no_regrant", 32'(n_vrd), 32'(1));

    // CPU write.
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h04000; cpu_wdata = 8'h3C;
    step();
    chk("cpu_wr1_oe", 32'(sram_oe), 32'(1));
    chk("cpu_wr1_vwr", 32'(n_vwr), 32'(1));
    chk("cpu_wr1_dout", 32'(sram_dout), 32'h3C);
    chk("cpu_wr1_wait", 32'(cpu_wait), 32'(1));
    step();
    chk("cpu_wr2_vwr", 32'(n_vwr), 32'(0));
    step();
    chk("cpu_wr3_vwr", 32'(n_vwr), 32'(1));
    chk("cpu_wr3_oe", 32'(sram_oe), 32'(1));
    step();
    chk("cpu_ack_n4", 32'(cpu_ack), 32'(1));
    chk("cpu_ack_wait", 32'(cpu_wait), 32'(0));
    chk("cpu_ack_oe", 32'(sram_oe), 32'(0));
    cpu_req = 0;
    step();

    // Collision: screen first, CPU back-to-back.
    scr_req = 1; scr_addr = 19'h00100; cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h00200;
    sram_din = 8'h5A;
    step();
    chk("col_scr_addr", 32'(sram_a), 32'h00100);
    step();
    step();
    chk("col_scr_ack", 32'(scr_ack), 32'(1));
    chk("col_cpu_addr", 32'(sram_a), 32'h00200);
    chk("col_no_idle", 32'(n_vrd), 32'(0));
    scr_req = 0; sram_din = 8'h77;
    step();
    step();
    chk("col_cpu_ack", 32'(cpu_ack), 32'(1));
    chk("col_cpu_rdata", 32'(cpu_rdata), 32'h77);
    cpu_req = 0;
    step();

    // Aux starvation against alternating screen and CPU traffic.
    scr_req = 1; cpu_req = 1; cpu_wr = 0;
    aux_valid = 1; aux_addr = 19'h01234; aux_data = 8'h99;
    step();
    aux_valid = 0;
    wait_aux_strobe(ncpu, found);
    chk("starve1_found", 32'(found), 32'(1));
    chk("starve1_cpu_wins", 32'(ncpu), 32'(8));
    chk("starve1_addr", 32'(sram_a), 32'h01234);
    chk("starve1_dout", 32'(sram_dout), 32'h99);
    chk("model_starve_clr", 32'(m_starve), 32'(0));
    aux_valid = 1; aux_addr = 19'h02345; aux_data = 8'h42;
    step();
    aux_valid = 0;
    if (cpu_ack) ncpu = 1; else ncpu = 0;
    begin
      int more;
      wait_aux_strobe(more, found);
      ncpu += more;
    end
    chk("starve2_found", 32'(found), 32'(1));
    chk("starve2_cpu_wins", 32'(ncpu), 32'(8));
    chk("starve2_addr", 32'(sram_a), 32'h02345);
    drain(60, nw, wa0, wa1);

    // FIFO full: third push ignored, accepted entries drain in order.
    scr_req = 1; cpu_req = 1; cpu_wr = 0;
    step(); step();
    aux_valid = 1; aux_addr = 19'h0AAAA; aux_data = 8'h11;
    step();
    chk("full_ready1", 32'(aux_ready), 32'(1));
    aux_addr = 19'h0BBBB; aux_data = 8'h22;
    step();
    chk("full_ready2", 32'(aux_ready), 32'(0));
    aux_addr = 19'h0CCCC; aux_data = 8'h33;
    step();
    chk("full_ready3", 32'(aux_ready), 32'(0));
    aux_valid = 0;
    drain(80, nw, wa0, wa1);
    chk("full_nwrites", 32'(nw), 32'(2));
    chk("full_first", 32'(wa0), 32'h0AAAA);
    chk("full_second", 32'(wa1), 32'h0BBBB);

    // Reset during the write strobe.
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h00555; cpu_wdata = 8'hE7;
    aux_valid = 1; aux_addr = 19'h00666; aux_data = 8'h01;
    step();
    aux_valid = 0;
    chk("rstw_wr1_oe", 32'(sram_oe), 32'(1));
    step();
    chk("rstw_wr2_vwr", 32'(n_vwr), 32'(0));
    rst_n = 0; cpu_req = 0;
    step();
    chk("rstw_vwr", 32'(n_vwr), 32'(1));
    chk("rstw_oe", 32'(sram_oe), 32'(0));
    chk("rstw_ready", 32'(aux_ready), 32'(1));
    chk("rstw_sram_a", 32'(sram_a), 32'(0));
    rst_n = 1;
    nstrobe = 0; nack = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!n_vwr) nstrobe++;
      if (cpu_ack) nack++;
    end
    chk("rstw_no_write", 32'(nstrobe), 32'(0));
    chk("rstw_no_ack", 32'(nack), 32'(0));

    // Randomised traffic obeying the request/ack protocol.
    for (int c = 0; c < 3000; c++) begin
      if (scr_req) begin
        if (scr_ack && $urandom_range(1, 0) == 0) scr_req = 0;
      end else if ($urandom_range(2, 0) == 0) scr_req = 1;
      if (cpu_req) begin
        if (cpu_ack && $urandom_range(1, 0) == 0) cpu_req = 0;
      end else if ($urandom_range(2, 0) == 0) cpu_req = 1;
      scr_addr  = AW'($urandom);
      cpu_addr  = AW'($urandom);
      aux_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      aux_data  = DW'($urandom);
      sram_din  = DW'($urandom);
      cpu_wr    = 1'($urandom);
      aux_valid = ($urandom_range(3, 0) == 0);
      rst_n     = ($urandom_range(399, 0) != 0);
      step();
    end
    rst_n = 1; aux_valid = 0;
    drain(40, nw, wa0, wa1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
